// File: rtl/sram_stream_reader.sv
// Burst read controller for a 1W1R SRAM macro; streams words on valid/ready.
// Optional stall counter output enabled with `define SRAM_RD_PERF_CNT_EN.
module sram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  sram_csb,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
`ifdef SRAM_RD_PERF_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic                  done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic                  infl_q;
    logic                  infl_last_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] mem_q  [FIFO_DEPTH];
    logic                  last_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;

    logic          accept;
    logic          pop;
    logic [CW-1:0] occ;
    logic          slot_free;
    logic          issue;
    logic          issue_last;

    assign accept     = cmd_valid & cmd_ready;
    assign pop        = m_valid & m_ready;
    assign occ        = count_q + CW'(infl_q);
    // A pop this cycle frees a slot for the read issued this cycle.
    assign slot_free  = (occ < CW'(FIFO_DEPTH)) | pop;
    assign issue      = ~rst & (state_q == ISSUE) & slot_free;
    assign issue_last = (issued_q == len_q - 1'b1);

    assign sram_csb  = ~issue;
    assign sram_addr = issue ? rd_addr_q : addr_q;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign m_valid   = (count_q != '0);
    assign m_data    = mem_q[rd_ptr_q];
    assign m_last    = last_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            infl_q      <= issue;
            infl_last_q <= issue & issue_last;
            if (issue) begin
                addr_q    <= rd_addr_q;
                rd_addr_q <= rd_addr_q + 1'b1;
                issued_q  <= issued_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept && cmd_len != '0) begin
                        rd_addr_q <= cmd_addr;
                        len_q     <= cmd_len;
                        issued_q  <= '0;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue && issue_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Word read last cycle is on sram_dout now; capture it unmodified.
    always_comb begin
        count_d = count_q + CW'(infl_q) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i]  <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (infl_q) begin
                mem_q[wr_ptr_q]  <= sram_dout;
                last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

`ifdef SRAM_RD_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (m_valid && !m_ready && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader with an SRAM model and burst scoreboard.
// Honours `define SRAM_RD_PERF_CNT_EN for the optional stall counter.
module tb_sram_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [8:0]  cmd_len;
    logic        sram_csb;
    logic [7:0]  sram_addr;
    logic [31:0] sram_dout;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
`ifdef SRAM_RD_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    sram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .sram_csb  (sram_csb),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
`ifdef SRAM_RD_PERF_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .done      (done)
    );

    logic [31:0] mem [256];

    always @(posedge clk) begin
        if (!sram_csb) sram_dout <= mem[sram_addr];
    end

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] last_addr = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0: ready always, 1: random ready, 2: ready low 5 cycles after first valid
    task automatic run_burst(input logic [7:0] a, input int len, input int mode);
        int   idx = 0;
        int   issued = 0;
        int   cyc = 0;
        int   first_iss = -1;
        int   last_hs = -1;
        int   stall_cyc = 0;
        int   stall_iss = 0;
        int   low_left = 0;
        bit   seen_valid = 0;
        bit   prev_stalled = 0;
        bit   fin = 0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        logic [7:0]  ea;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = len[8:0];
        m_ready   = 1'b1;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        chk("csb_idle", sram_csb, 1);
        while (!fin && cyc < len * 20 + 50) begin
            @(negedge clk);
            cyc++;
            if (last_hs >= 0) begin
                cmd_valid = 1'b0;
            end else begin
                cmd_valid = ($urandom % 4 == 0);
                cmd_addr  = 8'($urandom);
                cmd_len   = 9'($urandom);
            end
            case (mode)
                1: m_ready = ($urandom % 4 != 0);
                2: begin
                    if (!seen_valid && m_valid) begin
                        seen_valid = 1;
                        low_left   = 5;
                    end
                    m_ready = (low_left == 0);
                    if (low_left > 0) low_left--;
                end
                default: m_ready = 1'b1;
            endcase
            #1;
            if (last_hs >= 0) begin
                chk("done_pulse", done, 1);
                chk("busy_after", busy, 0);
                chk("cmd_ready_after", cmd_ready, 1);
                chk("valid_after", m_valid, 0);
                chk("csb_after", sram_csb, 1);
                fin = 1;
            end else begin
                chk("busy", busy, 1);
                chk("done_early", done, 0);
                chk("cmd_ready_busy", cmd_ready, 0);
                if (!sram_csb) begin
                    ea = a + 8'(issued);
                    chk("rd_addr", sram_addr, ea);
                    chk("over_issue", issued < len, 1);
                    if (first_iss < 0) first_iss = cyc;
                    if (m_valid && !m_ready) stall_iss++;
                    issued++;
                    last_addr = sram_addr;
                end
                if (m_valid) begin
                    if (prev_stalled) begin
                        chk("hold_data", m_data, prev_data);
                        chk("hold_last", m_last, prev_last);
                    end
                    if (m_ready) begin
                        ea = a + 8'(idx);
                        chk("m_data", m_data, mem[ea]);
                        chk("m_last", m_last, idx == len - 1);
                        if (idx == len - 1) last_hs = cyc;
                        idx++;
                        prev_stalled = 0;
                    end else begin
                        prev_stalled = 1;
                        prev_data    = m_data;
                        prev_last    = m_last;
                        stall_cyc++;
                    end
                end else begin
                    chk("valid_dropped", prev_stalled, 0);
                end
                chk("outstanding", (issued - idx) <= 2, 1);
            end
        end
        cmd_valid = 1'b0;
        chk("burst_timeout", fin, 1);
        chk("issue_count", issued, len);
        chk("word_count", idx, len);
        chk("first_issue", first_iss, 1);
        if (mode == 0) chk("throughput", last_hs - first_iss, len + 1);
        if (mode == 2) chk("stall_issues", stall_iss <= 2, 1);
`ifdef SRAM_RD_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, stall_cyc);
`endif
    endtask

    typedef struct {
        logic [7:0] addr;
        int         len;
        int         mode;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int hs;
        int budget;

        tbl[0] = '{addr: 8'h10, len: 4,   mode: 0};
        tbl[1] = '{addr: 8'hFE, len: 4,   mode: 0};
        tbl[2] = '{addr: 8'h00, len: 4,   mode: 2};
        tbl[3] = '{addr: 8'h80, len: 256, mode: 0};

        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        m_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_csb", sram_csb, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
`ifdef SRAM_RD_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif

        for (int i = 0; i < 4; i++) run_burst(tbl[i].addr, tbl[i].len, tbl[i].mode);

        // zero-length command is dropped
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 8'h05;
        cmd_len   = 9'd0;
        #1;
        chk("len0_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            chk("len0_cmd_ready", cmd_ready, 1);
            chk("len0_busy", busy, 0);
            chk("len0_done", done, 0);
            chk("len0_csb", sram_csb, 1);
            chk("len0_addr_hold", sram_addr, last_addr);
        end

        // reset after the 2nd word of an 8-word burst
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 8'h40;
        cmd_len   = 9'd8;
        m_ready   = 1'b1;
        hs        = 0;
        budget    = 0;
        while (hs < 2 && budget < 40) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            budget++;
            #1;
            if (m_valid && m_ready) hs++;
        end
        chk("rst_burst_timeout", hs, 2);
        @(negedge clk);
        rst     = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_csb", sram_csb, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_valid", m_valid, 0);
            chk("post_rst_done", done, 0);
            chk("post_rst_csb", sram_csb, 1);
        end
        run_burst(8'h33, 1, 0);

        // randomized bursts
        for (int i = 0; i < 12; i++) begin
            run_burst(8'($urandom), $urandom_range(1, 24), (i % 4 == 3) ? 2 : 1);
        end
        run_burst(8'hF0, 40, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
